// File: rtl/sm_feeder_mc_if.sv
// Loader/scoring-array bundle for the multi-channel feeder: record load side plus per-channel stream/result side.
// Pure wiring, no latency of its own.
// Backpressure: the loader must gate ld with full; the scoring array returns re pulses to release channels.
interface sm_feeder_mc_if #(
    parameter int TARGET_LENGTH = 128,
    parameter int LEN_WIDTH     = 12,
    parameter int ID_WIDTH      = 48,
    parameter int CHANNELS      = 2,
    parameter int DEPTH         = 4,
    parameter int IN_WIDTH      = ID_WIDTH + LEN_WIDTH + 2*TARGET_LENGTH
);
    logic                         ld;
    logic [IN_WIDTH-1:0]          feed_in;
    logic                         full;
    logic [$clog2(DEPTH+1)-1:0]   count;
    logic [CHANNELS-1:0]          re;
    logic [CHANNELS-1:0]          en;
    logic [1:0]                   data_out;
    logic [CHANNELS*ID_WIDTH-1:0] id_out;
    logic [CHANNELS-1:0]          busy;
    logic                         skip;

    // Host/DMA loader and scoring array together
    modport master (
        output ld, feed_in, re,
        input  full, count, en, data_out, id_out, busy, skip
    );

    // The feeder itself
    modport slave (
        input  ld, feed_in, re,
        output full, count, en, data_out, id_out, busy, skip
    );
endinterface

// File: rtl/sm_feeder_mc.sv
// Buffers target records and streams their 2-bit bases to any free channel of an interleaved scoring array.
// Latency: first en one cycle after the pop edge; a free channel with a queued record is granted from IDLE in one cycle.
// Backpressure: ld while full is dropped; a channel stays busy until its re pulse, stalling dispatch when none is free.
module sm_feeder_mc #(
    parameter int TARGET_LENGTH = 128,
    parameter int LEN_WIDTH     = 12,
    parameter int ID_WIDTH      = 48,
    parameter int CHANNELS      = 2,
    parameter int DEPTH         = 4,
    parameter int IN_WIDTH      = ID_WIDTH + LEN_WIDTH + 2*TARGET_LENGTH
) (
    input  logic          clk,
    input  logic          rst,
    sm_feeder_mc_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int RW = $clog2(TARGET_LENGTH + 1);
    localparam int BW = 2 * TARGET_LENGTH;

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] STREAM = 1'b1;

    localparam logic [LEN_WIDTH-1:0] MAX_LEN  = LEN_WIDTH'(TARGET_LENGTH);
    localparam logic [CW-1:0]        FULL_CNT = CW'(DEPTH);

    // FIFO storage and bookkeeping
    logic [IN_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [CW-1:0]       count_q, count_nx;
    logic                full_q;

    // Dispatch state
    logic [0:0]          state;
    logic [PW-1:0]       rr_ptr, cur_ch;
    logic [RW-1:0]       remain;
    logic [BW-1:0]       shreg;
    logic [CHANNELS-1:0] busy_q;
    logic [ID_WIDTH-1:0] id_q [CHANNELS];
    logic                skip_q;

    // Head-of-queue record fields
    logic [IN_WIDTH-1:0]  head;
    logic [ID_WIDTH-1:0]  head_id;
    logic [LEN_WIDTH-1:0] head_len, head_clamp;
    logic [BW-1:0]        head_bases;
    logic [RW-1:0]        head_l;

    logic                 push, pop, zero_len;
    logic                 grant_ok;
    logic [PW-1:0]        grant_ch, cand;
    logic [CHANNELS-1:0]  en_w;

    assign head       = mem[rd_ptr];
    assign head_id    = head[IN_WIDTH-1 -: ID_WIDTH];
    assign head_len   = head[BW +: LEN_WIDTH];
    assign head_bases = head[BW-1:0];
    assign head_clamp = (head_len > MAX_LEN) ? MAX_LEN : head_len;
    assign head_l     = RW'(head_clamp);
    assign zero_len   = (head_l == '0);

    assign push = bus.ld && !full_q;
    assign pop  = (state == IDLE) && (count_q != '0) && grant_ok;

    // Round-robin search for the first free channel after the last grant
    always_comb begin
        grant_ok = 1'b0;
        grant_ch = '0;
        cand     = '0;
        for (int i = 1; i <= CHANNELS; i++) begin
            cand = PW'((int'(rr_ptr) + i) % CHANNELS);
            if (!grant_ok && !busy_q[cand]) begin
                grant_ok = 1'b1;
                grant_ch = cand;
            end
        end
    end

    // Next occupancy; simultaneous push and pop cancel out
    always_comb begin
        count_nx = count_q;
        if (push && !pop)
            count_nx = count_q + CW'(1);
        else if (!push && pop)
            count_nx = count_q - CW'(1);
    end

    // Record storage write port (contents need no reset)
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= bus.feed_in;
    end

    // FIFO pointers, occupancy and registered full flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count_q <= count_nx;
            full_q  <= (count_nx == FULL_CNT);
        end
    end

    // Grant/stream FSM: pop into the shift register, then shift out one base per cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            rr_ptr <= PW'(CHANNELS - 1);
            cur_ch <= '0;
            remain <= '0;
            shreg  <= '0;
            skip_q <= 1'b0;
        end else begin
            skip_q <= pop && zero_len;
            case (state)
                IDLE: begin
                    if (pop) begin
                        rr_ptr <= grant_ch;
                        if (!zero_len) begin
                            cur_ch <= grant_ch;
                            remain <= head_l;
                            shreg  <= head_bases;
                            state  <= STREAM;
                        end
                    end
                end
                STREAM: begin
                    shreg  <= shreg >> 2;
                    remain <= remain - RW'(1);
                    if (remain == RW'(1))
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Per-channel ownership and target ID; re is ignored while idle or while that channel streams
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
            for (int c = 0; c < CHANNELS; c++)
                id_q[c] <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (pop && !zero_len && grant_ch == PW'(c)) begin
                    busy_q[c] <= 1'b1;
                    id_q[c]   <= head_id;
                end else if (bus.re[c] && !(state == STREAM && cur_ch == PW'(c))) begin
                    busy_q[c] <= 1'b0;
                end
            end
        end
    end

    // One-hot enable for the streaming channel only
    always_comb begin
        en_w = '0;
        if (state == STREAM)
            en_w[cur_ch] = 1'b1;
    end

    assign bus.en       = en_w;
    assign bus.data_out = (state == STREAM) ? shreg[1:0] : 2'b00;
    assign bus.full     = full_q;
    assign bus.count    = count_q;
    assign bus.busy     = busy_q;
    assign bus.skip     = skip_q;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_id
        assign bus.id_out[g*ID_WIDTH +: ID_WIDTH] = id_q[g];
    end
endmodule

// File: doc/sm_feeder_mc.md
Name: sm_feeder_mc

Overview:
- Multi-channel successor to the two-toggle scoring-module feeder.
- Buffers target records {id, length, bases} in a DEPTH-entry FIFO.
- Dispatches each record to any free channel of a CHANNELS-way interleaved ScoringModule, streaming 2-bit bases one per cycle under a one-hot enable.
- Holds each channel's target ID until that channel's result-valid pulse returns; sits between the host/DMA loader and the scoring array.

Parameters:
- TARGET_LENGTH, 128, maximum target bases per record
- LEN_WIDTH, 12, width of the record length field
- ID_WIDTH, 48, width of the record ID field
- CHANNELS, 2, number of interleaved scoring channels (at least 1)
- DEPTH, 4, FIFO entries (power of 2, at least 2)
- IN_WIDTH, ID_WIDTH+LEN_WIDTH+2*TARGET_LENGTH, record width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- ld  in  1  load request for feed_in
- feed_in  in  IN_WIDTH  record layout: [IN_WIDTH-1 -: ID_WIDTH] id; next LEN_WIDTH bits length; [2*TARGET_LENGTH-1:0] bases, base i at bits [2i+1:2i]
- full  out  1  FIFO holds DEPTH records
- count  out  $clog2(DEPTH+1)  FIFO occupancy
- re  in  CHANNELS  result-valid pulse per channel from the scoring module
- en  out  CHANNELS  one-hot (or zero) stream enable
- data_out  out  2  current base
- id_out  out  CHANNELS*ID_WIDTH  ID of the target on channel c, at [c*ID_WIDTH +: ID_WIDTH]
- busy  out  CHANNELS  channel c owns an unfinished target
- skip  out  1  one-cycle pulse when a zero-length record is discarded

Behaviour:
- Reset (asynchronous, immediate): FIFO empty; count=0; full=0; en=0; data_out=0; busy=0; id_out=0; skip=0; round-robin pointer=CHANNELS-1; FSM=IDLE. Reset during STREAM drops en at once and loses the in-flight record.
- Write: ld && !full pushes feed_in at the clock edge. ld while full is ignored; the record is lost and the loader must gate with full.
- full is registered from count; a pop in the same cycle does not admit a write while full=1.
- A simultaneous push and pop leaves count unchanged.
- FSM IDLE: if the FIFO is non-empty and some busy[c]=0, pop the head.
  - Grant the first free channel searching upward (wrapping) from pointer+1; set pointer to that channel.
  - Latch the clamped length L=min(len, TARGET_LENGTH) and the bases into a shift register.
  - If L=0: pulse skip next cycle; do not set busy; stay in IDLE.
  - Else: set busy[c]; write id_out[c]; go to STREAM.
- FSM STREAM: en[c]=1 and data_out=base k for k=0..L-1, one per cycle. The first en appears the cycle after the pop edge. After L cycles, en=0 and the FSM returns to IDLE.
  - busy[c] remains 1 after streaming.
  - At least one idle cycle separates consecutive streams.
- Release: re[c]=1 clears busy[c] at that edge. The channel is eligible for grant from the next cycle, not the same one.
  - id_out[c] stays valid during and after re[c] until the next grant overwrites it.
  - re[c] while busy[c]=0 is ignored.
  - re[c] during that channel's own STREAM is ignored; busy stays set.
- Multiple re bits may assert in the same cycle; each clears independently.
- Never assert more than one en bit.
- When data_out is not streaming, it is 0.

Test Plan:
- Reset, then load 3 records {id 1,2,3; len 4,5,6} with CHANNELS=2 -> id1 streams on ch0 4 cycles, id2 on ch1 5 cycles, id3 waits until re[0]; then id3 streams on ch0, id_out[0]=3.
- Hold ld high with no pops -> count reaches 4, full=1; a 5th ld is ignored; the first pop drops count to 3 and full deasserts the following cycle.
- Record len=0 (id 7) between two len=3 records -> skip pulses once, busy unchanged; the next record is granted to the next free channel.
- Record len=200 with TARGET_LENGTH=128 -> exactly 128 enable cycles; data_out sequence matches bases 0..127.
- Assert re[1] while ch1 is idle, and re[0] during ch0's own stream -> both ignored; busy and id_out are unchanged.
- Assert rst at stream cycle 2 of a len=10 record -> en, busy, count, and full are 0 immediately; after release, a new record streams normally from base 0.
